// File: rtl/mem_wr_sched_pkg.sv
`default_nettype none
// ============================================================================
// mem_wr_sched_pkg : shared types and defaults for the averaging-BRAM write scheduler
// Revision: 1.0
// ============================================================================
package mem_wr_sched_pkg;

   localparam int c_data_w = 16;
   localparam int c_addr_w = 3;
   localparam int c_depth  = 8;

   typedef logic [1:0] state_t;
   localparam state_t c_st_idle  = 2'd0;
   localparam state_t c_st_write = 2'd1;
   localparam state_t c_st_start = 2'd2;
   localparam state_t c_st_wait  = 2'd3;

   typedef enum logic {
      REQ_MED = 1'b0,
      REQ_CAL = 1'b1
   } req_id_t;

endpackage
`default_nettype wire

// File: rtl/clk_rstn_if.sv
`default_nettype none
// ============================================================================
// clk_rstn_if : clock and asynchronous active-low reset bundle
// Revision: 1.0
// ============================================================================
interface clk_rstn_if;
   logic clk_i;
   logic rstn_i;

   modport dut (input clk_i, input rstn_i);
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-way round-robin picker with one-cycle hold-off of the last acked requester
// Revision: 1.0
// ============================================================================
module rr_arb2
   import mem_wr_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);

   req_id_t    r_last;
   logic [1:0] r_gnt_d;
   logic [1:0] r_hold;
   logic [1:0] w_elig;
   logic [1:0] w_grant;

   // A grant at n is acked at n+1; the mask lands at n+2 while that requester drops req
   assign w_elig = i_req & ~r_hold;

   always_comb begin
      w_grant = 2'b00;
      if (i_en) begin
         if (&w_elig) begin
            w_grant = (r_last == REQ_MED) ? 2'b10 : 2'b01;
         end else begin
            w_grant = w_elig;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= REQ_CAL;
         r_gnt_d <= 2'b00;
         r_hold  <= 2'b00;
      end else begin
         r_gnt_d <= w_grant;
         r_hold  <= r_gnt_d;
         if (|w_grant) begin
            r_last <= w_grant[1] ? REQ_CAL : REQ_MED;
         end
      end
   end

   assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/mem_wr_sched.sv
`default_nettype none
// ============================================================================
// mem_wr_sched : shares BRAM port A between median and calibration writers, starts the reader per frame
// Revision: 1.0
// ============================================================================
module mem_wr_sched
   import mem_wr_sched_pkg::*;
#(
   parameter int DATA_W = c_data_w,
   parameter int ADDR_W = c_addr_w,
   parameter int DEPTH  = c_depth
)(
   clk_rstn_if.dut           interf,
   input  logic              req0_i,
   input  logic [DATA_W-1:0] data0_i,
   output logic              ack0_o,
   input  logic              req1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] data1_i,
   output logic              ack1_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   output logic              rd_start_o,
   input  logic              rd_done_i,
   output logic              busy_o,
   output logic [ADDR_W:0]   fill_o
);

   localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);

   logic              clk;
   logic              rst_n;
   logic [1:0]        w_grant;
   state_t            r_state;
   req_id_t           r_gnt_id;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_fill;
   logic              r_armed;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic              r_rd_start;
   logic              r_busy;

   assign clk   = interf.clk_i;
   assign rst_n = interf.rstn_i;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (r_state == c_st_idle),
      .i_req   ({req1_i, req0_i}),
      .o_grant (w_grant)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_st_idle;
         r_gnt_id   <= REQ_MED;
         r_wr_ptr   <= '0;
         r_fill     <= '0;
         r_armed    <= 1'b0;
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_din      <= '0;
         r_rd_start <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_ack0     <= 1'b0;
         r_ack1     <= 1'b0;
         r_we       <= 1'b0;
         r_rd_start <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (|w_grant) begin
                  r_state  <= c_st_write;
                  r_we     <= 1'b1;
                  r_ack0   <= w_grant[0];
                  r_ack1   <= w_grant[1];
                  r_gnt_id <= w_grant[1] ? REQ_CAL : REQ_MED;
                  r_addr   <= w_grant[1] ? addr1_i : r_wr_ptr;
                  r_din    <= w_grant[1] ? data1_i : data0_i;
               end
            end
            c_st_write: begin
               r_state <= c_st_idle;
               if (r_gnt_id == REQ_MED) begin
                  r_fill <= r_fill + 1'b1;
                  // The pointer parks on the last entry; only the reader hand-back rewinds it
                  if (r_wr_ptr == c_last_ptr) begin
                     r_state    <= c_st_start;
                     r_rd_start <= 1'b1;
                     r_busy     <= 1'b1;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
               end
            end
            c_st_start: begin
               r_state <= c_st_wait;
               r_armed <= 1'b0;
            end
            c_st_wait: begin
               // First WAIT_RD cycle ignores rd_done so a stale level from the last frame cannot leak
               r_armed <= 1'b1;
               if (r_armed && rd_done_i) begin
                  r_state  <= c_st_idle;
                  r_busy   <= 1'b0;
                  r_wr_ptr <= '0;
                  r_fill   <= '0;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign ack0_o     = r_ack0;
   assign ack1_o     = r_ack1;
   assign mem_we_o   = r_we;
   assign mem_addr_o = r_addr;
   assign mem_din_o  = r_din;
   assign rd_start_o = r_rd_start;
   assign busy_o     = r_busy;
   assign fill_o     = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_sched.sv
`default_nettype none
// ============================================================================
// tb_mem_wr_sched : directed stimulus with a cycle-level reference model for mem_wr_sched
// Revision: 1.0
// ============================================================================
module tb_mem_wr_sched;

   logic        clk;
   logic        rstn;
   logic        req0, req1, rd_done;
   logic [15:0] data0, data1;
   logic [2:0]  addr1;
   logic        ack0, ack1, we, rd_start, busy;
   logic [2:0]  maddr;
   logic [15:0] mdin;
   logic [3:0]  fill;

   int n_checks = 0;
   int n_errors = 0;

   clk_rstn_if u_if ();
   assign u_if.clk_i  = clk;
   assign u_if.rstn_i = rstn;

   mem_wr_sched #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
      .interf     (u_if),
      .req0_i     (req0),
      .data0_i    (data0),
      .ack0_o     (ack0),
      .req1_i     (req1),
      .addr1_i    (addr1),
      .data1_i    (data1),
      .ack1_o     (ack1),
      .mem_we_o   (we),
      .mem_addr_o (maddr),
      .mem_din_o  (mdin),
      .rd_start_o (rd_start),
      .rd_done_i  (rd_done),
      .busy_o     (busy),
      .fill_o     (fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and write log ----------------
   int   m_fill, m_idx, cyc, ack_cyc, st_cyc, n_starts;
   bit   m_busy, m_last, e_ack0, e_ack1, e_start, p_ack0, p_ack1;
   bit   x_ack0, x_ack1, x_start, x_busy, el0, el1;
   int   x_fill;
   logic       lg_cal[$];
   logic [2:0] lg_addr[$];
   logic [15:0] lg_data[$];

   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         chk("reset_outputs", {ack0, ack1, we, maddr, mdin, rd_start, busy, fill}, 32'h0);
         m_fill = 0; m_idx = 0; m_busy = 1'b0; m_last = 1'b1;
         e_ack0 = 1'b0; e_ack1 = 1'b0; e_start = 1'b0; p_ack0 = 1'b0; p_ack1 = 1'b0;
      end else begin
         chk("ack0", ack0, e_ack0);
         chk("ack1", ack1, e_ack1);
         chk("mem_we", we, e_ack0 | e_ack1);
         chk("rd_start", rd_start, e_start);
         chk("busy", busy, m_busy);
         chk("fill", fill, m_fill);
         if (e_ack0) begin
            chk("med_addr", maddr, m_fill);
            chk("med_data", mdin, data0);
         end
         if (e_ack1) begin
            chk("cal_addr", maddr, addr1);
            chk("cal_data", mdin, data1);
         end
         if (we) begin
            lg_cal.push_back(ack1);
            lg_addr.push_back(maddr);
            lg_data.push_back(mdin);
         end
         if (ack0 || ack1) ack_cyc = cyc;
         if (rd_start) begin st_cyc = cyc; n_starts++; end

         // predict the next cycle from the rules: one write per free idle cycle
         x_ack0 = 1'b0; x_ack1 = 1'b0; x_start = 1'b0;
         x_busy = m_busy; x_fill = m_fill;
         if (e_ack0 || e_ack1) begin
            if (e_ack0) begin
               x_fill = m_fill + 1;
               if (x_fill == 8) begin x_start = 1'b1; x_busy = 1'b1; end
            end
         end else if (m_busy) begin
            if (e_start) m_idx = 0;
            else if (m_idx >= 1 && rd_done) begin x_busy = 1'b0; x_fill = 0; end
            else m_idx++;
         end else begin
            el0 = req0 && !p_ack0;
            el1 = req1 && !p_ack1;
            if (el0 && el1) begin
               if (m_last) x_ack0 = 1'b1; else x_ack1 = 1'b1;
            end else begin
               x_ack0 = el0;
               x_ack1 = el1;
            end
            if (x_ack0) m_last = 1'b0;
            if (x_ack1) m_last = 1'b1;
         end
         p_ack0 = e_ack0; p_ack1 = e_ack1;
         e_ack0 = x_ack0; e_ack1 = x_ack1; e_start = x_start;
         m_busy = x_busy; m_fill = x_fill;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // requester keeps req one extra cycle after seeing ack, like a registered writer
   task automatic hold_ack0(input int max_cyc);
      int n;
      n = 0;
      while (ack0 !== 1'b1 && n < max_cyc) begin tick(1); n++; end
      chk("ack0_seen", ack0, 1'b1);
      tick(2);
      req0 = 1'b0;
   endtask

   task automatic hold_ack1(input int max_cyc);
      int n;
      n = 0;
      while (ack1 !== 1'b1 && n < max_cyc) begin tick(1); n++; end
      chk("ack1_seen", ack1, 1'b1);
      tick(2);
      req1 = 1'b0;
   endtask

   task automatic wr0(input logic [15:0] d);
      data0 = d;
      req0  = 1'b1;
      hold_ack0(30);
   endtask

   task automatic wr1(input logic [2:0] a, input logic [15:0] d);
      addr1 = a;
      data1 = d;
      req1  = 1'b1;
      hold_ack1(30);
   endtask

   task automatic chk_log(input int idx, input logic cal, input logic [2:0] a, input logic [15:0] d);
      if (idx >= lg_addr.size()) begin
         chk("log_missing", lg_addr.size(), idx + 1);
      end else begin
         chk("log_src", lg_cal[idx], cal);
         chk("log_addr", lg_addr[idx], a);
         chk("log_data", lg_data[idx], d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   int base;

   initial begin
      rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_done = 1'b0;
      data0 = '0; data1 = '0; addr1 = '0;
      tick(2);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fill", fill, 4'd0);
      rstn = 1'b1;
      tick(1);

      // full median frame 10..17
      base = lg_addr.size();
      for (int i = 0; i < 8; i++) wr0(16'(10 + i));
      for (int i = 0; i < 8; i++) chk_log(base + i, 1'b0, 3'(i), 16'(10 + i));
      chk("frame1_starts", n_starts, 1);
      chk("start_after_ack", st_cyc - ack_cyc, 1);
      chk("frame1_busy", busy, 1'b1);
      chk("frame1_fill", fill, 4'd8);

      // both writers blocked in WAIT_RD, then released by rd_done
      req0 = 1'b1; data0 = 16'h0A00;
      req1 = 1'b1; addr1 = 3'd6; data1 = 16'h0B06;
      base = lg_addr.size();
      tick(20);
      chk("waitrd_writes", lg_addr.size() - base, 0);
      chk("waitrd_busy", busy, 1'b1);
      fork
         hold_ack0(40);
         hold_ack1(40);
         begin rd_done = 1'b1; tick(1); rd_done = 1'b0; end
      join
      chk_log(base, 1'b1, 3'd6, 16'h0B06);
      chk_log(base + 1, 1'b0, 3'd0, 16'h0A00);

      // rd_done ignored in IDLE and in WRITE
      tick(1);
      rd_done = 1'b1; tick(1); rd_done = 1'b0;
      chk("idle_done_busy", busy, 1'b0);
      chk("idle_done_fill", fill, 4'd1);
      req0 = 1'b1; data0 = 16'h0C01;
      tick(1);
      chk("latency_ack0", ack0, 1'b1);
      rd_done = 1'b1; tick(1); rd_done = 1'b0;
      tick(1); req0 = 1'b0;
      chk("write_done_fill", fill, 4'd2);
      chk_log(lg_addr.size() - 1, 1'b0, 3'd1, 16'h0C01);

      // calibration write mid-frame
      wr0(16'h0C02);
      wr0(16'h0C03);
      chk("mid_fill", fill, 4'd4);
      wr1(3'd3, 16'hCA13);
      chk_log(lg_addr.size() - 1, 1'b1, 3'd3, 16'hCA13);
      chk("cal_fill", fill, 4'd4);
      wr0(16'h0C04);
      chk_log(lg_addr.size() - 1, 1'b0, 3'd4, 16'h0C04);
      for (int i = 5; i < 8; i++) wr0(16'(16'h0C00 + i));
      chk("frame2_busy", busy, 1'b1);
      tick(3);
      rd_done = 1'b1; tick(1); rd_done = 1'b0;
      tick(1);
      chk("frame2_exit_busy", busy, 1'b0);
      chk("frame2_exit_fill", fill, 4'd0);

      // asynchronous reset in the middle of a write
      for (int i = 0; i < 5; i++) wr0(16'(16'h0E00 + i));
      data0 = 16'h0E05; req0 = 1'b1;
      for (int n = 0; n < 10 && ack0 !== 1'b1; n++) tick(1);
      chk("pre_reset_we", we, 1'b1);
      #2 rstn = 1'b0;
      #1 chk("async_reset_outputs", {ack0, ack1, we, maddr, mdin, rd_start, busy, fill}, 32'h0);
      req0 = 1'b0;
      tick(1);
      rstn = 1'b1;
      tick(1);

      // collisions after reset: req0 wins first, alternation afterwards
      base = lg_addr.size();
      req0 = 1'b1; data0 = 16'h0D00;
      req1 = 1'b1; addr1 = 3'd5; data1 = 16'hBEEF;
      fork hold_ack0(30); hold_ack1(30); join
      wr0(16'h0D01);
      req0 = 1'b1; data0 = 16'h0D02;
      req1 = 1'b1; addr1 = 3'd2; data1 = 16'hBEF2;
      fork hold_ack0(30); hold_ack1(30); join
      for (int i = 3; i < 8; i++) wr0(16'(16'h0D00 + i));
      chk_log(base, 1'b0, 3'd0, 16'h0D00);
      chk_log(base + 1, 1'b1, 3'd5, 16'hBEEF);
      chk_log(base + 2, 1'b0, 3'd1, 16'h0D01);
      chk_log(base + 3, 1'b1, 3'd2, 16'hBEF2);
      chk_log(base + 4, 1'b0, 3'd2, 16'h0D02);
      for (int i = 3; i < 8; i++) chk_log(base + 2 + i, 1'b0, 3'(i), 16'(16'h0D00 + i));
      chk("total_starts", n_starts, 3);
      chk("frame3_fill", fill, 4'd8);
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
